// File: rtl/pio_ram_emu_responder_if.sv
// Two-pin PIO RAM link between the initiator (master) and the RAM responder (slave).
interface pio_ram_emu_responder_if;
  logic [1:0] rx_pins;
  logic [1:0] tx_pins;
  logic       busy;
  logic       protocol_err;

  modport master (output rx_pins, input tx_pins, busy, protocol_err);
  modport slave  (input rx_pins, output tx_pins, busy, protocol_err);
endinterface

// File: rtl/pio_ram_emu_responder.sv
// Responder end of the 2-pin PIO RAM link: decodes read/write frames into a word memory.
// Optional write acknowledge is built when PIO_RAM_EMU_WRITE_ACK_EN is defined.
module pio_ram_emu_responder #(
  parameter int ADDR_BITS  = 8,
  parameter int DATA_BITS  = 16,
  parameter int RESP_DELAY = 2
) (
  input logic                    clk,
  input logic                    rst_n,
  pio_ram_emu_responder_if.slave bus
);

  localparam int ADDR_SYMS = ADDR_BITS / 2;
  localparam int DATA_SYMS = DATA_BITS / 2;
  localparam int MAX_AD    = (ADDR_SYMS > DATA_SYMS) ? ADDR_SYMS : DATA_SYMS;
  localparam int CNT_MAX   = (MAX_AD > RESP_DELAY) ? MAX_AD : RESP_DELAY;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t ADDR_LAST = cnt_t'(ADDR_SYMS - 1);
  localparam cnt_t DATA_LAST = cnt_t'(DATA_SYMS - 1);
  localparam cnt_t DATA_END  = cnt_t'(DATA_SYMS);
  localparam cnt_t DELAY_END = cnt_t'(RESP_DELAY);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WDATA, S_WAIT, S_RESP} state_t;

  state_t                 state_q, state_d;
  logic                   is_wr_q, is_wr_d;
  cnt_t                   cnt_q, cnt_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic [1:0]             tx_q, tx_d;
  logic                   busy_q;
  logic                   err_q, err_d;
  logic                   mem_we;
  logic                   resp_done;
  logic [DATA_BITS-1:0]   data_shift;

  logic [DATA_BITS-1:0]   mem [0:(1<<ADDR_BITS)-1];

  assign data_shift = DATA_BITS'({data_q, bus.rx_pins});

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    is_wr_d   = is_wr_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    tx_d      = 2'b00;
    err_d     = err_q;
    mem_we    = 1'b0;
    resp_done = (cnt_q == DATA_END);
`ifdef PIO_RAM_EMU_WRITE_ACK_EN
    resp_done = resp_done | is_wr_q;
`endif

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        case (bus.rx_pins)
          2'b01: begin state_d = S_ADDR; is_wr_d = 1'b0; end
          2'b10: begin state_d = S_ADDR; is_wr_d = 1'b1; end
          2'b11: err_d = 1'b1;
          default: ;
        endcase
      end

      S_ADDR: begin
        addr_d = ADDR_BITS'({addr_q, bus.rx_pins});
        if (cnt_q == ADDR_LAST) begin
          cnt_d   = '0;
          state_d = is_wr_q ? S_WDATA : S_WAIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_WDATA: begin
        data_d = data_shift;
        if (cnt_q == DATA_LAST) begin
          mem_we = 1'b1;
          cnt_d  = '0;
`ifdef PIO_RAM_EMU_WRITE_ACK_EN
          state_d = S_WAIT;
`else
          state_d = S_IDLE;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // Half duplex: the initiator must stay quiet until the response is over.
      S_WAIT: begin
        if (bus.rx_pins != 2'b00) err_d = 1'b1;
        data_d = mem[addr_q];
        if (cnt_q == DELAY_END) begin
          cnt_d   = '0;
          state_d = S_RESP;
`ifdef PIO_RAM_EMU_WRITE_ACK_EN
          tx_d = is_wr_q ? 2'b10 : 2'b01;
`else
          tx_d = 2'b01;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_RESP: begin
        if (bus.rx_pins != 2'b00) err_d = 1'b1;
        if (resp_done) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          tx_d   = data_q[DATA_BITS-1 -: 2];
          data_d = DATA_BITS'({data_q, 2'b00});
          cnt_d  = cnt_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      is_wr_q <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      tx_q    <= 2'b00;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      is_wr_q <= is_wr_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
      busy_q  <= (state_d != S_IDLE);
      err_q   <= err_d;
    end
  end

  // NOTE: the memory array is deliberately not reset so it maps onto block/distributed RAM.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) mem[addr_q] <= data_shift;
  end

  assign bus.tx_pins      = tx_q;
  assign bus.busy         = busy_q;
  assign bus.protocol_err = err_q;

endmodule

// File: tb/tb_pio_ram_emu_responder.sv
// Self-checking bench: a per-edge timeline model of tx_pins/busy/protocol_err built from
// frame-level rules, checked every cycle, plus literal response captures.
module tb_pio_ram_emu_responder;
  localparam int AB = 8;
  localparam int DB = 16;
  localparam int RD = 2;
  localparam int AS = AB / 2;
  localparam int DS = DB / 2;
  localparam int N  = 1024;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pio_ram_emu_responder_if bus ();

  pio_ram_emu_responder #(.ADDR_BITS(AB), .DATA_BITS(DB), .RESP_DELAY(RD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int edge_n = 0;

  bit [1:0]    exp_tx   [N];
  bit          exp_busy [N];
  bit          err_set  [N];
  bit          rst_at   [N];
  bit [DB-1:0] mdl_mem  [1<<AB];
  bit          m_err = 1'b0;

  logic [2*DS+1:0] cap;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Every edge: outputs after edge n must equal the timeline model for edge n.
  always @(negedge clk) begin
    if (edge_n > 0 && edge_n < N) begin
      if (rst_at[edge_n]) m_err = 1'b0;
      else                m_err = m_err | err_set[edge_n];
      check($sformatf("tx@%0d", edge_n),   bus.tx_pins,      32'(exp_tx[edge_n]));
      check($sformatf("busy@%0d", edge_n), bus.busy,         32'(exp_busy[edge_n]));
      check($sformatf("err@%0d", edge_n),  bus.protocol_err, 32'(m_err));
    end
  end

  // Symbol is sampled at the next posedge; edge_n then holds that edge's index.
  task automatic tick(input logic [1:0] sym);
    bus.rx_pins = sym;
    @(posedge clk);
    edge_n++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(2'b00);
  endtask

  task automatic reset_cycle();
    rst_n = 1'b0;
    rst_at[edge_n+1] = 1'b1;
    for (int e = edge_n + 1; e < N; e++) begin
      exp_tx[e]   = 2'b00;
      exp_busy[e] = 1'b0;
    end
    tick(2'b00);
    rst_n = 1'b1;
  endtask

  task automatic do_write(input logic [AB-1:0] addr, input logic [DB-1:0] data);
    logic [2*(1+AS+DS)-1:0] frame;
    int e0, w;
    frame = {2'b10, addr, data};
    e0 = edge_n + 1;
    w  = e0 + AS + DS;
    for (int e = e0; e < w; e++) exp_busy[e] = 1'b1;
    mdl_mem[addr] = data;
`ifdef PIO_RAM_EMU_WRITE_ACK_EN
    for (int e = w; e <= w + 1 + RD; e++) exp_busy[e] = 1'b1;
    exp_tx[w+1+RD] = 2'b10;
`endif
    for (int i = 0; i <= AS + DS; i++) tick(frame[2*(AS+DS)+1-2*i -: 2]);
`ifdef PIO_RAM_EMU_WRITE_ACK_EN
    idle(RD + 2);
`endif
  endtask

  // mode 0: clean read; 1: rx=01 at start+off; 2: reset at start+off.
  task automatic do_read(input logic [AB-1:0] addr, input int mode, input int off,
                         output logic [2*DS+1:0] got);
    logic [2*DS+1:0] resp;
    int e0, k, start, fin;
    logic [1:0] sym;
    got   = '0;
    resp  = {2'b01, mdl_mem[addr]};
    e0    = edge_n + 1;
    k     = e0 + AS;
    start = k + 1 + RD;
    fin   = start + 1 + DS;
    for (int e = e0; e < fin; e++) exp_busy[e] = 1'b1;
    for (int i = 0; i <= DS; i++) exp_tx[start+i] = resp[2*DS+1-2*i -: 2];
    tick(2'b01);
    for (int i = 0; i < AS; i++) tick(addr[AB-1-2*i -: 2]);
    for (int e = k + 1; e <= fin; e++) begin
      if (mode == 2 && e == start + off) begin
        reset_cycle();
        return;
      end
      sym = (mode == 1 && e == start + off) ? 2'b01 : 2'b00;
      if (sym != 2'b00) err_set[e] = 1'b1;
      tick(sym);
      if (e >= start && e < fin) got = {got[2*DS-1:0], bus.tx_pins};
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    bus.rx_pins = 2'b00;
    reset_cycle();
    reset_cycle();
    check("reset_tx", bus.tx_pins, 32'd0);
    check("reset_busy", bus.busy, 32'd0);
    check("reset_err", bus.protocol_err, 32'd0);
    idle(2);

    // Write 0x3C <- 0xBEEF, then read it back after an idle gap.
    do_write(8'h3C, 16'hBEEF);
    idle(3);
    do_read(8'h3C, 0, 0, cap);
    check("read_3C_literal", 32'(cap), 32'h1BEEF);  // 01 10 11 11 10 11 10 11 11

    // Back-to-back read directly after the last write data symbol.
    do_write(8'h3C, 16'hC0DE);
    do_read(8'h3C, 0, 0, cap);
    check("b2b_C0DE_literal", 32'(cap), 32'h1C0DE);
    do_write(8'h3C, 16'hBEEF);
    do_read(8'h3C, 0, 0, cap);
    check("b2b_BEEF_literal", 32'(cap), 32'h1BEEF);

    // Address and data extremes.
    do_write(8'h00, 16'hFFFF);
    do_write(8'hFF, 16'h0001);
    idle(1);
    do_read(8'h00, 0, 0, cap);
    check("read_00_literal", 32'(cap), 32'h1FFFF);
    do_read(8'hFF, 0, 0, cap);
    check("read_FF_literal", 32'(cap), 32'h10001);

    // rx=01 during RESP: flag set, response unchanged.
    do_read(8'h3C, 1, 2, cap);
    check("disturbed_read_literal", 32'(cap), 32'h1BEEF);
    check("disturbed_err", bus.protocol_err, 32'd1);
    idle(2);
    reset_cycle();
    check("err_cleared_by_reset", bus.protocol_err, 32'd0);
    idle(1);

    // Reserved opcode in IDLE.
    tick(2'b11);
    err_set[edge_n] = 1'b1;
    check("reserved_err", bus.protocol_err, 32'd1);
    check("reserved_busy", bus.busy, 32'd0);
    check("reserved_tx", bus.tx_pins, 32'd0);
    idle(3);

    // Reset mid-RESP aborts the response; memory survives.
    do_read(8'h3C, 2, 3, cap);
    check("midresp_rst_tx", bus.tx_pins, 32'd0);
    check("midresp_rst_busy", bus.busy, 32'd0);
    idle(2);
    do_read(8'h3C, 0, 0, cap);
    check("after_reset_literal", 32'(cap), 32'h1BEEF);

`ifdef PIO_RAM_EMU_WRITE_ACK_EN
    do_write(8'h01, 16'h1234);
    do_read(8'h01, 0, 0, cap);
    check("ack_read_literal", 32'(cap), 32'h11234);
`endif

    idle(3);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
